// File: rtl/mix_column.sv
// AES MixColumns over a 128-bit column-major state (byte 0 at the MSB).
// Latency: 1 cycle, full throughput. Backpressure: none, a state is accepted every cycle.
module mix_column (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  input  logic [127:0] mixcolumn_i,
  output logic         valid_o,
  output logic [127:0] mixcolumn_o
);

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  // One column: rows are rotations of {02,03,01,01}; 3x = 2x ^ x.
  function automatic logic [31:0] mix_word(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    b0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
    b3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  logic [127:0] mixed;

  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[127-32*c -: 32] = mix_word(mixcolumn_i[127-32*c -: 32]);
    end
  end

  // Output register only loads on valid_i so an idle input cannot disturb it.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o     <= 1'b0;
      mixcolumn_o <= '0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        mixcolumn_o <= mixed;
      end
    end
  end

endmodule

// File: tb/tb_mix_column.sv
// Self-checking bench for mix_column: GF(2^8) matrix model, per-cycle compare, literal vectors.
module tb_mix_column;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_i;
  logic [127:0] mixcolumn_i;
  logic         valid_o;
  logic [127:0] mixcolumn_o;

  int n_cmp = 0;
  int n_err = 0;

  mix_column dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .mixcolumn_i (mixcolumn_i),
    .valid_o     (valid_o),
    .mixcolumn_o (mixcolumn_o)
  );

  always #5 clk = ~clk;

  // Generic GF(2^8) multiply, shift-and-add with the AES polynomial.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // Full state as a 4x4 byte matrix times the circulant MixColumns matrix.
  function automatic logic [127:0] ref_mix(input logic [127:0] s);
    logic [7:0] coef [4];
    logic [7:0] a [16];
    logic [7:0] acc;
    logic [127:0] r;
    coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    for (int n = 0; n < 16; n++) a[n] = s[127-8*n -: 8];
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef[(k - row + 4) % 4], a[4*c+k]);
        r[127-8*(4*c+row) -: 8] = acc;
      end
    end
    return r;
  endfunction

  // Expected registered outputs, tracked from the sampled inputs.
  logic         m_live = 1'b0;
  logic         m_valid;
  logic [127:0] m_data;

  always @(posedge clk) begin
    if (rst) begin
      m_live  <= 1'b1;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      m_valid <= valid_i;
      if (valid_i) m_data <= ref_mix(mixcolumn_i);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        n_cmp++;
        if (valid_o !== m_valid || mixcolumn_o !== m_data) begin
          n_err++;
          $display("FAIL model_cmp t=%0t valid_o=%b mixcolumn_o=%h required valid_o=%b mixcolumn_o=%h",
                   $time, valid_o, mixcolumn_o, m_valid, m_data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [128:0] act, input logic [128:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] V2_IN  = 128'hDB135345_F20A225C_01010101_C6C6C6C6;
  localparam logic [127:0] V2_OUT = 128'h8E4DA1BC_9FDC589D_01010101_C6C6C6C6;
  localparam logic [127:0] V3_IN  = 128'h95D88CA6C34AE746EC904C6E974DF287;
  localparam logic [127:0] V3_OUT = 128'h6817BFA7E223967F4A6D562F9787B708;
  localparam logic [127:0] V4_IN  = 128'hD4D4D4D5_2D26314C_00000000_FFFFFFFF;
  localparam logic [127:0] V4_OUT = 128'hD5D5D7D6_4D7EBDF8_00000000_FFFFFFFF;

  initial begin
    logic [127:0] vin [3];
    logic [127:0] vout [3];
    logic [127:0] rnd;
    logic [7:0]   b;
    vin[0] = V2_IN;  vin[1] = V3_IN;  vin[2] = V4_IN;
    vout[0] = V2_OUT; vout[1] = V3_OUT; vout[2] = V4_OUT;

    // Pin the model itself against known vectors.
    check("model_v2", {1'b0, ref_mix(V2_IN)}, {1'b0, V2_OUT});
    check("model_v3", {1'b0, ref_mix(V3_IN)}, {1'b0, V3_OUT});
    check("model_v4", {1'b0, ref_mix(V4_IN)}, {1'b0, V4_OUT});

    rst = 1'b1;
    valid_i = 1'b0;
    mixcolumn_i = '0;
    step();
    step();
    check("reset_state", {valid_o, mixcolumn_o}, 129'h0);
    rst = 1'b0;
    step();
    check("idle_after_reset", {valid_o, mixcolumn_o}, 129'h0);

    // Isolated vectors with an idle cycle between each.
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'b1;
      mixcolumn_i = vin[i];
      step();
      check($sformatf("vector%0d", i + 2), {valid_o, mixcolumn_o}, {1'b1, vout[i]});
      valid_i = 1'b0;
      mixcolumn_i = $urandom();
      step();
      check($sformatf("hold%0d", i + 2), {valid_o, mixcolumn_o}, {1'b0, vout[i]});
    end

    // Back-to-back, then drop valid_i.
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'b1;
      mixcolumn_i = vin[i];
      step();
      check($sformatf("b2b%0d", i), {valid_o, mixcolumn_o}, {1'b1, vout[i]});
    end
    valid_i = 1'b0;
    step();
    check("b2b_drop_hold", {valid_o, mixcolumn_o}, {1'b0, V4_OUT});

    // Fixed points.
    valid_i = 1'b1;
    mixcolumn_i = '0;
    step();
    check("zero_fixed", {valid_o, mixcolumn_o}, 129'h1_00000000_00000000_00000000_00000000);
    mixcolumn_i = 128'h5A5A5A5A_00000000_E1E1E1E1_37373737;
    step();
    check("equal_col_fixed", {valid_o, mixcolumn_o}, {1'b1, 128'h5A5A5A5A_00000000_E1E1E1E1_37373737});

    // Reset while valid_i is high discards the result.
    mixcolumn_i = V3_IN;
    rst = 1'b1;
    step();
    check("reset_midstream", {valid_o, mixcolumn_o}, 129'h0);
    rst = 1'b0;
    mixcolumn_i = V2_IN;
    step();
    check("first_after_reset", {valid_o, mixcolumn_o}, {1'b1, V2_OUT});

    // Random traffic checked by the per-cycle compare.
    for (int i = 0; i < 1000; i++) begin
      rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
      if ($urandom_range(0, 7) == 0) begin
        for (int c = 0; c < 4; c++) begin
          b = rnd[127-32*c -: 8];
          rnd[127-32*c -: 32] = {b, b, b, b};
        end
      end
      valid_i = ($urandom_range(0, 3) != 0);
      mixcolumn_i = rnd;
      rst = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0;
    valid_i = 1'b0;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not reach the end, required completion");
    $fatal(1, "timeout");
  end

endmodule
